// File: rtl/coin_payer.sv
// coin_payer: pays a purchase amount as a train of coin pulses to the vending
// block, then waits for the cola-delivered pulse or gives up after TIMEOUT.
// Optional feature macro: COIN_PAYER_ONE_COIN_EN -- when defined, one-yuan
// coins are paid greedily; when undefined every coin is a half-yuan pulse and
// po_money_one is tied low.
module coin_payer #(
    parameter int unsigned GAP     = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic [3:0] amount,
    input  logic       pi_cola,
    input  logic       pi_money,
    output logic       po_money_one,
    output logic       po_money_half,
    output logic       busy,
    output logic       done,
    output logic       cola_ok,
    output logic       change_ok,
    output logic       timeout,
    output logic [3:0] coins_sent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COIN,
        S_GAP,
        S_WAIT,
        S_FIN
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] remaining_q, remaining_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] coins_sent_q, coins_sent_d;
    logic       cola_ok_q, cola_ok_d;
    logic       change_ok_q, change_ok_d;
    logic       timeout_q, timeout_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       half_q, half_d;
`ifdef COIN_PAYER_ONE_COIN_EN
    logic       one_q, one_d;
`endif

    // A coin is issued on the edge that enters COIN, so the pulse register is
    // loaded together with the state; issue_rem is the balance being paid from.
    logic       issue;
    logic [3:0] issue_rem;
    logic       sel_one;

    // Balance the next coin is taken from, and which coin it will be.
    always_comb begin
        issue_rem = (state_q == S_IDLE) ? amount : remaining_q;
`ifdef COIN_PAYER_ONE_COIN_EN
        sel_one = (issue_rem >= 4'd2);
`else
        sel_one = 1'b0;
`endif
    end

    // Next-state, counters, status flags and registered output values.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        cnt_d        = cnt_q;
        coins_sent_d = coins_sent_q;
        cola_ok_d    = cola_ok_q;
        change_ok_d  = change_ok_q;
        timeout_d    = timeout_q;
        issue        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cola_ok_d    = 1'b0;
                    change_ok_d  = 1'b0;
                    timeout_d    = 1'b0;
                    coins_sent_d = '0;
                    cnt_d        = '0;
                    if (amount == 4'd0) begin
                        state_d = S_FIN;
                    end else begin
                        issue   = 1'b1;
                        state_d = S_COIN;
                    end
                end
            end
            S_COIN: begin
                cnt_d = '0;
                if (pi_cola) begin
                    state_d = S_FIN;
                end else if (remaining_q != 4'd0) begin
                    state_d = S_GAP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_GAP: begin
                if (pi_cola) begin
                    state_d = S_FIN;
                end else if (cnt_q == GAP_LAST) begin
                    issue   = 1'b1;
                    state_d = S_COIN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (pi_cola) begin
                    state_d = S_FIN;
                end else if (cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_FIN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE) begin
            if (pi_cola) begin
                cola_ok_d = 1'b1;
            end
            if (pi_money) begin
                change_ok_d = 1'b1;
            end
        end

        if (issue) begin
            remaining_d  = issue_rem - (sel_one ? 4'd2 : 4'd1);
            coins_sent_d = coins_sent_d + 4'd1;
        end

        half_d = issue && !sel_one;
`ifdef COIN_PAYER_ONE_COIN_EN
        one_d  = issue && sel_one;
`endif
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            cnt_q        <= '0;
            coins_sent_q <= '0;
            cola_ok_q    <= 1'b0;
            change_ok_q  <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            half_q       <= 1'b0;
`ifdef COIN_PAYER_ONE_COIN_EN
            one_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            cnt_q        <= cnt_d;
            coins_sent_q <= coins_sent_d;
            cola_ok_q    <= cola_ok_d;
            change_ok_q  <= change_ok_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            half_q       <= half_d;
`ifdef COIN_PAYER_ONE_COIN_EN
            one_q        <= one_d;
`endif
        end
    end

`ifdef COIN_PAYER_ONE_COIN_EN
    assign po_money_one  = one_q;
`else
    assign po_money_one  = 1'b0;
`endif
    assign po_money_half = half_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cola_ok       = cola_ok_q;
    assign change_ok     = change_ok_q;
    assign timeout       = timeout_q;
    assign coins_sent    = coins_sent_q;

endmodule

// File: tb/tb_coin_payer.sv
// Self-checking bench for coin_payer: table of purchases with expected
// outcomes, a queue of expected coin kinds, plus reset and idle sequences.
module tb_coin_payer;

    localparam int unsigned TB_GAP = 2;
    localparam int unsigned TB_TO  = 16;
`ifdef COIN_PAYER_ONE_COIN_EN
    localparam bit ONE_EN = 1'b1;
`else
    localparam bit ONE_EN = 1'b0;
`endif

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start     = 1'b0;
    logic [3:0] amount    = 4'd0;
    logic       pi_cola   = 1'b0;
    logic       pi_money  = 1'b0;
    logic       po_money_one;
    logic       po_money_half;
    logic       busy;
    logic       done;
    logic       cola_ok;
    logic       change_ok;
    logic       timeout;
    logic [3:0] coins_sent;

    coin_payer #(.GAP(TB_GAP), .TIMEOUT(TB_TO)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .amount       (amount),
        .pi_cola      (pi_cola),
        .pi_money     (pi_money),
        .po_money_one (po_money_one),
        .po_money_half(po_money_half),
        .busy         (busy),
        .done         (done),
        .cola_ok      (cola_ok),
        .change_ok    (change_ok),
        .timeout      (timeout),
        .coins_sent   (coins_sent)
    );

    always #5 sys_clk = ~sys_clk;

    // Sample indices count observation points (#1 after each rising edge)
    // from the one where start is driven (index 0).
    typedef struct {
        int amt;
        int cola_at;
        int money_at;
        int restart;     // 0 none, 1 start again at sample 2, 2 start during FIN
        int exp_done;
        int exp_coins;
        int exp_cola;
        int exp_change;
        int exp_to;
    } vec_t;

    vec_t vecs[10];
    bit   exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic int n_coins(input int amt);
        return ONE_EN ? (amt + 1) / 2 : amt;
    endfunction

    function automatic int last_pulse(input int amt);
        return 1 + (n_coins(amt) - 1) * int'(TB_GAP + 1);
    endfunction

    function automatic vec_t make_vec(input int amt, input int cola_at,
                                      input int money_at, input int restart);
        vec_t v;
        int   last;
        v.amt      = amt;
        v.cola_at  = cola_at;
        v.money_at = money_at;
        v.restart  = restart;
        last       = last_pulse(amt);
        if (amt == 0) begin
            v.exp_done  = 1;
            v.exp_coins = 0;
            v.exp_cola  = 0;
            v.exp_to    = 0;
        end else if (cola_at > 0 && cola_at <= last + int'(TB_TO)) begin
            v.exp_done  = cola_at + 1;
            v.exp_coins = 0;
            for (int i = 0; i < n_coins(amt); i++) begin
                if (1 + i * int'(TB_GAP + 1) <= cola_at) v.exp_coins++;
            end
            v.exp_cola = 1;
            v.exp_to   = 0;
        end else begin
            v.exp_done  = last + 1 + int'(TB_TO);
            v.exp_coins = n_coins(amt);
            v.exp_cola  = 0;
            v.exp_to    = 1;
        end
        v.exp_change = (money_at > 0) ? 1 : 0;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int seen = 0;
        int rem  = v.amt;
        for (int i = 0; i < v.exp_coins; i++) begin
            if (ONE_EN && rem >= 2) begin
                exp_q.push_back(1'b1);
                rem -= 2;
            end else begin
                exp_q.push_back(1'b0);
                rem -= 1;
            end
        end
        start  = 1'b1;
        amount = 4'(v.amt);
        for (int s = 1; s <= v.exp_done + 1; s++) begin
            @(posedge sys_clk);
            #1;
            if (po_money_one || po_money_half) begin
                seen++;
                check({tag, ".exclusive"}, int'(po_money_one && po_money_half), 0);
                if (exp_q.size() == 0) begin
                    check({tag, ".extra_pulse"}, 1, 0);
                end else begin
                    check({tag, ".kind_one"}, int'(po_money_one), int'(exp_q.pop_front()));
                end
                check({tag, ".pulse_time"}, s, 1 + (seen - 1) * int'(TB_GAP + 1));
            end
            if (s <= v.exp_done) check({tag, ".busy"}, int'(busy), 1);
            if (s == v.exp_done) begin
                check({tag, ".done"}, int'(done), 1);
                check({tag, ".cola_ok"}, int'(cola_ok), v.exp_cola);
                check({tag, ".change_ok"}, int'(change_ok), v.exp_change);
                check({tag, ".timeout"}, int'(timeout), v.exp_to);
                check({tag, ".coins_sent"}, int'(coins_sent), v.exp_coins);
            end
            if (s == v.exp_done + 1) begin
                check({tag, ".done_after"}, int'(done), 0);
                check({tag, ".busy_after"}, int'(busy), 0);
                check({tag, ".cola_hold"}, int'(cola_ok), v.exp_cola);
                check({tag, ".coins_hold"}, int'(coins_sent), v.exp_coins);
            end
            start    = (v.restart == 1 && s == 2) || (v.restart == 2 && s == v.exp_done);
            amount   = start ? 4'd9 : 4'hF;
            pi_cola  = (s == v.cola_at);
            pi_money = (s == v.money_at);
        end
        start    = 1'b0;
        pi_cola  = 1'b0;
        pi_money = 1'b0;
        check({tag, ".pulse_count"}, seen, v.exp_coins);
        check({tag, ".queue_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = make_vec(5,  last_pulse(5) + 1,      -1, 0);
        vecs[1] = make_vec(6,  last_pulse(6) + 1,      last_pulse(6) + 1, 0);
        vecs[2] = make_vec(1,  -1,                     -1, 0);
        vecs[3] = make_vec(0,  -1,                     -1, 0);
        vecs[4] = make_vec(4,  last_pulse(4) + 1,      -1, 1);
        vecs[5] = make_vec(2,  last_pulse(2) + int'(TB_TO), -1, 0);
        vecs[6] = make_vec(3,  -1,                     2, 0);
        vecs[7] = make_vec(8,  2,                      -1, 0);
        vecs[8] = make_vec(15, last_pulse(15) + 3,     -1, 2);
        vecs[9] = make_vec(9,  last_pulse(9) + 1,      -1, 1);

        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_state",
              int'({busy, done, cola_ok, change_ok, timeout, po_money_one, po_money_half, coins_sent}), 0);
        sys_rst_n = 1'b1;

        // Vending pulses while idle must not touch the flags.
        pi_cola  = 1'b1;
        pi_money = 1'b1;
        @(posedge sys_clk);
        #1;
        pi_cola  = 1'b0;
        pi_money = 1'b0;
        @(posedge sys_clk);
        #1;
        check("idle_ignore",
              int'({busy, cola_ok, change_ok, coins_sent}), 0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the gap after the second coin, then a fresh purchase.
        start  = 1'b1;
        amount = 4'd7;
        for (int s = 1; s <= 5; s++) begin
            @(posedge sys_clk);
            #1;
            start  = 1'b0;
            amount = 4'hF;
            if (s == 1 || s == 4) check("rst_seq.pulse", int'(po_money_one | po_money_half), 1);
            if (s == 5) check("rst_seq.gap_busy", int'({busy, coins_sent}), int'({1'b1, 4'd2}));
        end
        sys_rst_n = 1'b0;
        #1;
        check("rst_seq.outputs_cleared",
              int'({busy, done, cola_ok, change_ok, timeout, po_money_one, po_money_half, coins_sent}), 0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        exp_q.delete();
        run_vec(make_vec(2, last_pulse(2) + 1, -1, 0), "post_reset");

        repeat (2) @(posedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
